// File: rtl/ts_sync_receiver.sv
`timescale 1ns/1ps
// ts_sync_receiver: MPEG-2 TS sync hunter/locker with aligned byte output, header extraction and statistics.
// Define TS_CC_CHECK_EN to add the continuity-counter check on packets with PID == CC_PID.
module ts_sync_receiver #(
  parameter int PKT_LEN    = 188,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 3
`ifdef TS_CC_CHECK_EN
  ,
  parameter logic [12:0] CC_PID = 13'h0100
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_eof,
  output logic        locked,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        pkt_start,
  output logic        pkt_end,
  output logic [7:0]  byte_idx,
  output logic [12:0] pid,
  output logic        pid_valid,
  output logic        tei,
  output logic        cc_err,
  output logic [31:0] pkt_cnt,
  output logic [15:0] loss_cnt
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX_C   = 8'(PKT_LEN - 1);
  localparam logic [7:0] LOCK_CNT_C   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_CNT_C = 8'(UNLOCK_CNT);
  localparam logic [7:0] SYNC_BYTE_C  = 8'h47;

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic [7:0]  conf_r;
  logic [7:0]  miss_r;
  logic [4:0]  pid_hi_r;

  state_t      nxt_state_s;
  logic [7:0]  nxt_cnt_s;
  logic [7:0]  nxt_conf_s;
  logic [7:0]  nxt_miss_s;
  logic        fwd_s;
  logic        start_s;
  logic        loss_inc_s;
  logic        boundary_s;
  logic        is_sync_s;
  logic [7:0]  cnt_inc_s;

  assign boundary_s = (cnt_r == 8'd0);
  assign is_sync_s  = (in_data == SYNC_BYTE_C);
  assign cnt_inc_s  = (cnt_r == LAST_IDX_C) ? 8'd0 : cnt_r + 8'd1;

  // Next-state decode for one accepted byte, followed by the end-of-stream flush
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    nxt_conf_s  = conf_r;
    nxt_miss_s  = miss_r;
    fwd_s       = 1'b0;
    start_s     = 1'b0;
    loss_inc_s  = 1'b0;
    if (in_valid) begin
      case (state_r)
        HUNT: begin
          if (is_sync_s) begin
            nxt_cnt_s = cnt_inc_s;
            if (LOCK_CNT_C == 8'd1) begin
              nxt_state_s = LOCKED;
              nxt_miss_s  = 8'd0;
              nxt_conf_s  = 8'd0;
              fwd_s       = 1'b1;
              start_s     = 1'b1;
            end else begin
              nxt_state_s = VERIFY;
              nxt_conf_s  = 8'd1;
            end
          end else begin
            nxt_cnt_s = 8'd0;
          end
        end
        VERIFY: begin
          if (boundary_s) begin
            if (is_sync_s) begin
              nxt_cnt_s = cnt_inc_s;
              if ((conf_r + 8'd1) == LOCK_CNT_C) begin
                nxt_state_s = LOCKED;
                nxt_conf_s  = 8'd0;
                nxt_miss_s  = 8'd0;
                fwd_s       = 1'b1;
                start_s     = 1'b1;
              end else begin
                nxt_conf_s = conf_r + 8'd1;
              end
            end else begin
              // A failed boundary is dropped outright rather than reconsidered as a new sync
              nxt_state_s = HUNT;
              nxt_conf_s  = 8'd0;
              nxt_cnt_s   = 8'd0;
            end
          end else begin
            nxt_cnt_s = cnt_inc_s;
          end
        end
        LOCKED: begin
          nxt_cnt_s = cnt_inc_s;
          fwd_s     = 1'b1;
          if (boundary_s) begin
            start_s = 1'b1;
            if (is_sync_s) begin
              nxt_miss_s = 8'd0;
            end else if ((miss_r + 8'd1) == UNLOCK_CNT_C) begin
              nxt_state_s = HUNT;
              nxt_cnt_s   = 8'd0;
              nxt_miss_s  = 8'd0;
              nxt_conf_s  = 8'd0;
              fwd_s       = 1'b0;
              start_s     = 1'b0;
              loss_inc_s  = 1'b1;
            end else begin
              nxt_miss_s = miss_r + 8'd1;
            end
          end else begin
            nxt_miss_s = miss_r;
          end
        end
        default: begin
          nxt_state_s = HUNT;
          nxt_cnt_s   = 8'd0;
          nxt_conf_s  = 8'd0;
          nxt_miss_s  = 8'd0;
        end
      endcase
    end else begin
      nxt_state_s = state_r;
    end
    if (in_eof) begin
      nxt_state_s = HUNT;
      nxt_cnt_s   = 8'd0;
      nxt_conf_s  = 8'd0;
      nxt_miss_s  = 8'd0;
    end else begin
      nxt_cnt_s = nxt_cnt_s;
    end
  end

  // State, counters, header fields and the registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= HUNT;
      cnt_r     <= 8'd0;
      conf_r    <= 8'd0;
      miss_r    <= 8'd0;
      pid_hi_r  <= 5'd0;
      locked    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      pkt_start <= 1'b0;
      pkt_end   <= 1'b0;
      byte_idx  <= 8'd0;
      pid       <= 13'd0;
      pid_valid <= 1'b0;
      tei       <= 1'b0;
      pkt_cnt   <= 32'd0;
      loss_cnt  <= 16'd0;
    end else begin
      state_r   <= nxt_state_s;
      cnt_r     <= nxt_cnt_s;
      conf_r    <= nxt_conf_s;
      miss_r    <= nxt_miss_s;
      locked    <= (nxt_state_s == LOCKED);
      out_valid <= fwd_s;
      pkt_start <= start_s;
      pkt_end   <= fwd_s && (cnt_r == LAST_IDX_C);
      pid_valid <= fwd_s && (cnt_r == 8'd2);
      if (fwd_s) begin
        out_data <= in_data;
        byte_idx <= cnt_r;
        if (cnt_r == 8'd1) begin
          tei      <= in_data[7];
          pid_hi_r <= in_data[4:0];
        end
        if (cnt_r == 8'd2) begin
          pid <= {pid_hi_r, in_data};
        end
      end
      if (start_s) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
      if (loss_inc_s && (loss_cnt != 16'hFFFF)) begin
        loss_cnt <= loss_cnt + 16'd1;
      end
    end
  end

`ifdef TS_CC_CHECK_EN
  logic [3:0] prev_cc_r;
  logic       cc_loaded_r;
  logic       cc_hit_s;
  logic [3:0] exp_cc_s;

  // pid already holds the current packet's PID when byte 3 arrives
  assign cc_hit_s = fwd_s && (cnt_r == 8'd3) && (pid == CC_PID);
  assign exp_cc_s = in_data[4] ? (prev_cc_r + 4'd1) : prev_cc_r;

  // Continuity tracking; the first CC_PID packet after each lock only seeds prev_cc_r
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cc_r   <= 4'd0;
      cc_loaded_r <= 1'b0;
      cc_err      <= 1'b0;
    end else begin
      cc_err <= 1'b0;
      if (nxt_state_s != LOCKED) begin
        cc_loaded_r <= 1'b0;
      end else if (cc_hit_s) begin
        prev_cc_r   <= in_data[3:0];
        cc_loaded_r <= 1'b1;
        cc_err      <= cc_loaded_r && (in_data[3:0] != exp_cc_s);
      end
    end
  end
`else
  assign cc_err = 1'b0;
`endif

endmodule
